// File: rtl/divu_hilo_unit_if.sv
// divu_hilo_unit_if: EX-stage bundle between the ALU decode/hazard logic and the HI/LO divide unit.
// Latency: none, wires only.
// Backpressure: stall flows back to the pipeline; master drives the op, slave returns result/status.
interface divu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       ALUOperation;
  logic             op_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             stall;
  logic             div_zero;

  modport master (
    output ALUOperation, op_valid, src_a, src_b,
    input  result, busy, done, stall, div_zero
  );

  modport slave (
    input  ALUOperation, op_valid, src_a, src_b,
    output result, busy, done, stall, div_zero
  );
endinterface

// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit: owns HI/LO, runs a radix-2 restoring unsigned divider (divu), serves mfhi/mflo.
// Latency: divu done in cycle WIDTH+1 after accept (cycle 1 for src_b==0, or for src_b>src_a with DIVU_EARLY_OUT_EN); reads are combinational.
// Backpressure: while busy, divu/mfhi/mflo raise stall and must be re-presented; other ops pass through. Optional macro: DIVU_EARLY_OUT_EN.
module divu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  divu_hilo_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_MFHI = 4'b1000;
  localparam logic [3:0] OP_MFLO = 4'b1001;

  logic [1:0]       state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             div_zero_q;

  logic             is_divu;
  logic             is_hilo_op;
  logic             busy_w;
  logic             stall_w;
  logic             early_out;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quo_sh;

  assign is_divu    = bus.op_valid && (bus.ALUOperation == OP_DIVU);
  assign is_hilo_op = (bus.ALUOperation == OP_DIVU) ||
                      (bus.ALUOperation == OP_MFHI) ||
                      (bus.ALUOperation == OP_MFLO);
  assign busy_w     = (state == ST_RUN) || (state == ST_FIN);
  assign stall_w    = bus.op_valid && busy_w && is_hilo_op;

`ifdef DIVU_EARLY_OUT_EN
  // Quotient is trivially zero when the divisor exceeds the dividend.
  assign early_out = (bus.src_b > bus.src_a);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor; the
  // sign bit of the trial decides both the new remainder and the quotient bit.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, dvs};
  assign quo_sh = {quo[WIDTH-2:0], ~trial[WIDTH+1]};

  // HI/LO readback is gated by stall so a read during FIN returns the fresh value next cycle.
  always_comb begin
    bus.result = '0;
    if (bus.op_valid && !stall_w) begin
      if (bus.ALUOperation == OP_MFHI) begin
        bus.result = hi;
      end else if (bus.ALUOperation == OP_MFLO) begin
        bus.result = lo;
      end
    end
  end

  assign bus.busy     = busy_w;
  assign bus.stall    = stall_w;
  assign bus.done     = (state == ST_FIN);
  assign bus.div_zero = div_zero_q;

  // Divider FSM and HI/LO update; HI/LO are only written on the FIN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hi         <= '0;
      lo         <= '0;
      quo        <= '0;
      dvs        <= '0;
      rem        <= '0;
      cnt        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_divu) begin
            if (bus.src_b == '0) begin
              // Divide by zero: skip iterations, publish all-ones quotient and the dividend.
              quo        <= '1;
              rem        <= {1'b0, bus.src_a};
              div_zero_q <= 1'b1;
              state      <= ST_FIN;
            end else if (early_out) begin
              quo   <= '0;
              rem   <= {1'b0, bus.src_a};
              state <= ST_FIN;
            end else begin
              quo   <= bus.src_a;
              dvs   <= bus.src_b;
              rem   <= '0;
              cnt   <= '0;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem <= trial[WIDTH+1] ? rem_sh[WIDTH:0] : trial[WIDTH:0];
          quo <= quo_sh;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          lo    <= quo;
          hi    <= rem[WIDTH-1:0];
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// tb_divu_hilo_unit: scoreboard bench for divu/mfhi/mflo, stall, done timing, div_zero and async reset.
// Latency: expected done cycle computed by the bench model per divide.
// Backpressure: stalled ops are re-presented every cycle until stall drops.
module tb_divu_hilo_unit;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_MFHI = 4'b1000;
  localparam logic [3:0] OP_MFLO = 4'b1001;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  divu_hilo_unit_if #(.WIDTH(32)) bus ();

  divu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read mid-cycle.
  task automatic step(input logic [3:0] op, input logic vld, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.ALUOperation = op;
    bus.op_valid     = vld;
    bus.src_a        = a;
    bus.src_b        = b;
    #4;
  endtask

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
`ifdef DIVU_EARLY_OUT_EN
    if (b > a) return 1;
`endif
    return 33;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.lo  = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    e.hi  = (b == 32'd0) ? a : a % b;
    e.lat = model_lat(a, b);
    exp_q.push_back(e);
  endtask

  // Steps with the given op held until done; 'start' is the cycle index already reached.
  task automatic wait_done(input string tag, input logic [3:0] op, input logic vld,
                           input logic [31:0] a, input logic [31:0] b, input int start);
    exp_t e;
    int   k;
    logic seen;
    seen = 1'b0;
    k    = start;
    while (!seen && (k < start + 100)) begin
      step(op, vld, a, b);
      k++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_sb_entry"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_latency"}, 64'(k), 64'(e.lat));
      last_lo = e.lo;
      last_hi = e.hi;
    end
  endtask

  task automatic run_divu(input string tag, input logic [31:0] a, input logic [31:0] b);
    push_exp(a, b);
    step(OP_DIVU, 1'b1, a, b);
    wait_done(tag, OP_ADD, 1'b0, 32'd0, 32'd0, 0);
    step(OP_MFLO, 1'b1, 32'd0, 32'd0);
    check({tag, "_lo"}, 64'(bus.result), 64'(last_lo));
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    step(OP_MFHI, 1'b1, 32'd0, 32'd0);
    check({tag, "_hi"}, 64'(bus.result), 64'(last_hi));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_lo = '0;
    last_hi = '0;
    rst_n   = 1'b0;
    bus.ALUOperation = OP_ADD;
    bus.op_valid     = 1'b0;
    bus.src_a        = '0;
    bus.src_b        = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(OP_MFLO, 1'b1, 32'd0, 32'd0);
    check("rst_mflo", 64'(bus.result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    step(OP_MFHI, 1'b1, 32'd0, 32'd0);
    check("rst_mfhi", 64'(bus.result), 64'd0);

    // 100/7 with mflo held from the next cycle.
    push_exp(32'd100, 32'd7);
    step(OP_DIVU, 1'b1, 32'd100, 32'd7);
    step(OP_MFLO, 1'b1, 32'd0, 32'd0);
    check("d100_c1_stall", 64'(bus.stall), 64'd1);
    check("d100_c1_busy", 64'(bus.busy), 64'd1);
    check("d100_c1_result", 64'(bus.result), 64'd0);
    wait_done("d100", OP_MFLO, 1'b1, 32'd0, 32'd0, 1);
    check("d100_fin_stall", 64'(bus.stall), 64'd1);
    check("d100_fin_result", 64'(bus.result), 64'd0);
    step(OP_MFLO, 1'b1, 32'd0, 32'd0);
    check("d100_stall_drop", 64'(bus.stall), 64'd0);
    check("d100_lo", 64'(bus.result), 64'(last_lo));
    step(OP_MFHI, 1'b1, 32'd0, 32'd0);
    check("d100_hi", 64'(bus.result), 64'(last_hi));

    run_divu("dmax_1", 32'hFFFF_FFFF, 32'd1);
    check("pre_dz_flag", 64'(bus.div_zero), 64'd0);
    run_divu("d5_0", 32'd5, 32'd0);
    check("dz_flag_set", 64'(bus.div_zero), 64'd1);
    run_divu("d3_10", 32'd3, 32'd10);
    check("dz_flag_sticky", 64'(bus.div_zero), 64'd1);

    // Back-to-back: non-divide op alongside, second divu held from cycle 5.
    push_exp(32'd100, 32'd7);
    step(OP_DIVU, 1'b1, 32'd100, 32'd7);
    for (int i = 1; i <= 4; i++) begin
      step(OP_ADD, 1'b1, 32'd1, 32'd2);
      if (i == 1) begin
        check("b2b_add_nostall", 64'(bus.stall), 64'd0);
        check("b2b_add_busy", 64'(bus.busy), 64'd1);
      end
    end
    push_exp(32'd9, 32'd3);
    wait_done("b2b_first", OP_DIVU, 1'b1, 32'd9, 32'd3, 4);
    check("b2b_fin_stall", 64'(bus.stall), 64'd1);
    step(OP_DIVU, 1'b1, 32'd9, 32'd3);
    check("b2b_accept_stall", 64'(bus.stall), 64'd0);
    wait_done("b2b_second", OP_ADD, 1'b0, 32'd0, 32'd0, 0);
    step(OP_MFLO, 1'b1, 32'd0, 32'd0);
    check("b2b_lo", 64'(bus.result), 64'(last_lo));
    step(OP_MFHI, 1'b1, 32'd0, 32'd0);
    check("b2b_hi", 64'(bus.result), 64'(last_hi));

    // Asynchronous reset in the middle of a divide.
    push_exp(32'd100, 32'd7);
    step(OP_DIVU, 1'b1, 32'd100, 32'd7);
    repeat (10) step(OP_ADD, 1'b0, 32'd0, 32'd0);
    check("mid_busy_before", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_div_zero", 64'(bus.div_zero), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(OP_MFLO, 1'b1, 32'd0, 32'd0);
    check("arst_lo", 64'(bus.result), 64'd0);
    check("arst_busy_after", 64'(bus.busy), 64'd0);
    step(OP_MFHI, 1'b1, 32'd0, 32'd0);
    check("arst_hi", 64'(bus.result), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
